bus_ack_model: RTL

BUS_ACK_MODEL -- requirements
Module: bus_ack_model

---
 rtl/bus_model_pkg.sv | 23 ++
 rtl/bus_ack_channel.sv | 119 +++++++++++
 rtl/bus_ack_model.sv | 50 +++++
 3 files changed

// File: rtl/bus_model_pkg.sv
// bus_model_pkg: shared types and helpers for the bus ack model.
// Holds the per-channel FSM state encoding and a counter-width check
// used at elaboration to validate the stall bound against CNT_W.
// Related build macro: BUS_ACK_FAIRNESS_EN (consumed in bus_ack_channel).
package bus_model_pkg;

  // Per-channel handshake state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ch_state_e;

  // True when a counter of cnt_w bits can hold the value max_stall,
  // i.e. max_stall < 2**cnt_w.
  function automatic bit cnt_width_ok(input int cnt_w, input int max_stall);
    if (max_stall < 0) begin
      return 1'b0;
    end
    return ($clog2(max_stall + 1) <= cnt_w);
  endfunction

endpackage : bus_model_pkg

// File: rtl/bus_ack_channel.sv
// bus_ack_channel: one independent bus channel of the ack model.
// Turns a free-running ack proposal into a legal single-cycle ack,
// tracks stall cycles and keeps sticky abort/timeout flags.
// Build macro BUS_ACK_FAIRNESS_EN: when defined, an ack is forced once
// the stall counter reaches MAX_STALL and the timeout flag never sets;
// when undefined, no ack is forced and the timeout flag latches instead.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no request outstanding, ack impossible
// WAIT    | request outstanding, counting stall cycles, ack allowed
// RESP    | one-cycle gap after an ack, ack held low
module bus_ack_channel
  import bus_model_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int MIN_LAT   = 0,
  parameter int MAX_STALL = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_cyc,
  input  logic             i_ack_req,
  output logic             o_ack,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout,
  output logic             o_abort
);

  localparam logic [CNT_W-1:0] LP_MIN_LAT   = CNT_W'(MIN_LAT);
  localparam logic [CNT_W-1:0] LP_MAX_STALL = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] LP_CNT_SAT   = {CNT_W{1'b1}};

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             r_abort;

  logic w_in_wait;
  logic w_lat_ok;
  logic w_force;
  logic w_to_hit;
  logic w_ack;

  assign w_in_wait = (r_state == ST_WAIT);

  // With no minimum latency every WAIT cycle qualifies; keeping this as a
  // generate branch avoids an always-true unsigned compare.
  if (MIN_LAT == 0) begin : g_lat_none
    assign w_lat_ok = 1'b1;
  end else begin : g_lat_min
    assign w_lat_ok = (r_cnt >= LP_MIN_LAT);
  end

`ifdef BUS_ACK_FAIRNESS_EN
  // A request that has stalled MAX_STALL cycles is acked regardless of
  // the proposal, so the timeout condition can never be observed.
  assign w_force  = (r_cnt == LP_MAX_STALL);
  assign w_to_hit = 1'b0;
`else
  assign w_force  = 1'b0;
  assign w_to_hit = w_in_wait & i_cyc & ~reset & (r_cnt == LP_MAX_STALL);
`endif

  // The ack is combinational so the core sees it in the same cycle the
  // proposal arrives; reset and a dropped request both kill it.
  assign w_ack = w_in_wait & i_cyc & ~reset & w_lat_ok & (i_ack_req | w_force);

  assign o_ack       = w_ack;
  assign o_busy      = w_in_wait;
  assign o_stall_cnt = r_cnt;
  // The flag is visible in the very cycle the bound is reached, then held.
  assign o_timeout   = r_timeout | w_to_hit;
  assign o_abort     = r_abort;

  // Channel FSM with stall counter and sticky status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_cyc) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (!i_cyc) begin
            // Core gave up before any ack arrived.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b1;
          end else if (w_ack) begin
            r_state <= ST_RESP;
            r_cnt   <= '0;
          end else if (r_cnt != LP_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule : bus_ack_channel

// File: rtl/bus_ack_model.sv
// bus_ack_model: multi-channel legal-ack generator for a bus master.
// Each channel (ch0 = ibus, ch1 = dbus by default) is an independent
// bus_ack_channel; the top only validates parameters and packs outputs.
// Build macro BUS_ACK_FAIRNESS_EN selects forced-ack versus timeout flag.
module bus_ack_model
  import bus_model_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 4,
  parameter int MIN_LAT   = 0,
  parameter int MAX_STALL = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       i_cyc,
  input  logic [N_CH-1:0]       i_ack_req,
  output logic [N_CH-1:0]       o_ack,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH*CNT_W-1:0] o_stall_cnt,
  output logic [N_CH-1:0]       o_timeout,
  output logic [N_CH-1:0]       o_abort
);

  // Reject configurations where the latency window or stall bound cannot
  // be represented, or where there is no channel at all.
  if (!((N_CH >= 1) && (MIN_LAT >= 0) && (MIN_LAT <= MAX_STALL) &&
        cnt_width_ok(CNT_W, MAX_STALL))) begin : g_bad_cfg
    $error("bus_ack_model: need N_CH>=1 and 0<=MIN_LAT<=MAX_STALL<2**CNT_W");
  end

  // One channel per bus; ch0 occupies the low counter bits.
  for (genvar g_i = 0; g_i < N_CH; g_i++) begin : g_ch
    bus_ack_channel #(
      .CNT_W     (CNT_W),
      .MIN_LAT   (MIN_LAT),
      .MAX_STALL (MAX_STALL)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .i_cyc       (i_cyc[g_i]),
      .i_ack_req   (i_ack_req[g_i]),
      .o_ack       (o_ack[g_i]),
      .o_busy      (o_busy[g_i]),
      .o_stall_cnt (o_stall_cnt[g_i*CNT_W +: CNT_W]),
      .o_timeout   (o_timeout[g_i]),
      .o_abort     (o_abort[g_i])
    );
  end

endmodule : bus_ack_model
